imm_narrow: RTL and testbench

//   Immediate narrowing encoder: inverse of the decode-stage immediate extender.

---
 rtl/imm_narrow.sv | 155 +++++++++++++++
 tb/tb_imm_narrow.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_narrow.sv
// imm_narrow: immediate narrowing encoder (inverse of the decode-stage
// immediate extender). Takes a 16-bit value and a target immediate mode and
// produces the 11-bit instruction immediate field plus a fit flag. The field
// re-extends to the original value only when fit=1.
//
// Two-stage valid/ready pipeline:
//   stage 1 registers the item and judges fit for all four modes,
//   stage 2 is the output register (out_*), which also selects the field.
// err_count counts delivered unfit items and saturates at all-ones.
//
// Optional feature, macro AUTO_MODE_EN:
//   defined   -> in_mode is ignored; out_mode is the first fitting mode in
//                priority 00,01,10,11. If none fits, out_mode=11 and out_fit=0.
//   undefined -> out_mode = in_mode, and fit is judged for that mode only.
module imm_narrow #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_value,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_field,
    output logic [1:0]       out_mode,
    output logic             out_fit,
    output logic [ERR_W-1:0] err_count
);

    // Immediate modes as encoded in the instruction format.
    typedef enum logic [1:0] {
        MODE_ZEXT5  = 2'b00,
        MODE_SEXT5  = 2'b01,
        MODE_SEXT8  = 2'b10,
        MODE_SEXT11 = 2'b11
    } mode_e;

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    // Stage 1 state.
    logic        s1_valid;
    logic [15:0] s1_value;
    logic [3:0]  s1_fit;     // bit i = value fits mode i

    // Fit of the incoming value for every mode.
    logic [3:0]  fit_now;

    // Stage 2 load selection.
    mode_e       sel_mode;
    logic        sel_fit;
    logic [10:0] sel_field;

    // Handshake helpers.
    logic        s2_free;
    logic        out_fire;

`ifdef AUTO_MODE_EN
    // Mode is chosen from the value alone; in_mode has no effect here.
    logic unused_mode;
    assign unused_mode = ^in_mode;
`else
    mode_e       s1_mode;
`endif

    // Output register can take a new item when empty or being drained.
    assign s2_free  = !out_valid || out_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 1 is free when empty or when stage 2 can take its item.
    assign in_ready = !s1_valid || !out_valid || out_ready;

    // Fit judgement for all modes: the bits above the field's sign/msb
    // position must be zero (zext5) or all copies of the sign bit (sextN).
    always_comb begin
        fit_now    = '0;
        fit_now[0] = (in_value[15:5] == '0);
        fit_now[1] = (in_value[15:4] == '0) || (in_value[15:4] == '1);
        fit_now[2] = (in_value[15:7] == '0) || (in_value[15:7] == '1);
        fit_now[3] = (in_value[15:10] == '0) || (in_value[15:10] == '1);
    end

    // Stage 1 register: captures an accepted item and its fit vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_value <= '0;
            s1_fit   <= '0;
`ifndef AUTO_MODE_EN
            s1_mode  <= MODE_ZEXT5;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_value <= in_value;
                s1_fit   <= fit_now;
`ifndef AUTO_MODE_EN
                s1_mode  <= mode_e'(in_mode);
`endif
            end
        end
    end

    // Mode selection and field truncation for the item leaving stage 1.
    always_comb begin
`ifdef AUTO_MODE_EN
        if (s1_fit[0]) begin
            sel_mode = MODE_ZEXT5;
        end else if (s1_fit[1]) begin
            sel_mode = MODE_SEXT5;
        end else if (s1_fit[2]) begin
            sel_mode = MODE_SEXT8;
        end else begin
            sel_mode = MODE_SEXT11;
        end
`else
        sel_mode = s1_mode;
`endif
        sel_fit = s1_fit[sel_mode];
        case (sel_mode)
            MODE_ZEXT5,
            MODE_SEXT5:  sel_field = {6'b0, s1_value[4:0]};
            MODE_SEXT8:  sel_field = {3'b0, s1_value[7:0]};
            default:     sel_field = s1_value[10:0];
        endcase
    end

    // Stage 2 output register: holds while stalled, reloads when free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_field <= '0;
            out_mode  <= MODE_ZEXT5;
            out_fit   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_field <= sel_field;
                out_mode  <= sel_mode;
                out_fit   <= sel_fit;
            end
        end
    end

    // Saturating count of unfit items handed to the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (out_fire && !out_fit && (err_count != '1)) begin
            err_count <= err_count + ERR_ONE;
        end
    end

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: randomized and directed stimulus for imm_narrow, checked
// every cycle against a queue-based behavioural model that derives field,
// mode and fit from signed/unsigned value ranges. Honours AUTO_MODE_EN.
module tb_imm_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_field;
    logic [1:0]  out_mode;
    logic        out_fit;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    imm_narrow #(.ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_mode  (out_mode),
        .out_fit   (out_fit),
        .err_count (err_count)
    );

    typedef struct {
        logic [15:0] v;
        logic [1:0]  m;
        int          a;   // posedge number at which the item was accepted
    } item_t;

    item_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    ncyc        = 0;
    int    err_m       = 0;
    int    delivered   = 0;
    bit    model_live  = 0;
    bit    prev_stall  = 0;
    int    prev_out    = 0;

    // Reference: range-based fit, first-fit auto mode, modulo field.
    function automatic void model(input logic [15:0] v, input logic [1:0] m,
                                  output logic [10:0] f, output logic [1:0] om,
                                  output logic fit);
        int uv;
        int sv;
        bit fits[4];
        uv = int'(v);
        sv = int'($signed(v));
        fits[0] = (uv < 32);
        fits[1] = (sv >= -16) && (sv <= 15);
        fits[2] = (sv >= -128) && (sv <= 127);
        fits[3] = (sv >= -1024) && (sv <= 1023);
`ifdef AUTO_MODE_EN
        if (fits[0]) om = 2'd0;
        else if (fits[1]) om = 2'd1;
        else if (fits[2]) om = 2'd2;
        else om = 2'd3;
`else
        om = m;
`endif
        fit = fits[om];
        if (om < 2)       f = 11'(uv % 32);
        else if (om == 2) f = 11'(uv % 256);
        else              f = 11'(uv % 2048);
    endfunction

    // Decode-stage re-extension of a field, as a 16-bit pattern.
    function automatic int reext(input logic [10:0] f, input logic [1:0] m);
        int r;
        r = int'(f);
        case (m)
            2'd0: r = r % 32;
            2'd1: begin r = r % 32;  if (r >= 16)   r = r - 32;   end
            2'd2: begin r = r % 256; if (r >= 128)  r = r - 256;  end
            default: begin           if (r >= 1024) r = r - 2048; end
        endcase
        return r & 32'hFFFF;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by the
    // transfers that the coming posedge will perform.
    always @(negedge clk) begin
        logic [10:0] f;
        logic [1:0]  om;
        logic        ft;
        bit          exp_valid;
        ncyc++;
        if (model_live) begin
            exp_valid = (q.size() > 0) && (ncyc >= q[0].a + 1);
            chk("in_ready", int'(in_ready), int'((q.size() < 2) || out_ready));
            chk("out_valid", int'(out_valid), int'(exp_valid));
            if (out_valid && q.size() > 0) begin
                model(q[0].v, q[0].m, f, om, ft);
                chk("out_field", int'(out_field), int'(f));
                chk("out_mode", int'(out_mode), int'(om));
                chk("out_fit", int'(out_fit), int'(ft));
                if (out_fit)
                    chk("roundtrip", reext(out_field, out_mode), int'(q[0].v));
            end
            if (prev_stall)
                chk("stall_hold", int'({out_valid, out_field, out_mode, out_fit}), prev_out);
            chk("err_count", int'(err_count), err_m);
        end
        if (rst) begin
            q.delete();
            err_m      = 0;
            model_live = 1;
            prev_stall = 0;
        end else if (model_live) begin
            prev_stall = out_valid && !out_ready;
            prev_out   = int'({out_valid, out_field, out_mode, out_fit});
            if (out_valid && out_ready && q.size() > 0) begin
                model(q[0].v, q[0].m, f, om, ft);
                if (!ft && err_m < 255) err_m++;
                void'(q.pop_front());
                delivered++;
            end
            if (in_valid && in_ready)
                q.push_back('{v: in_value, m: in_mode, a: ncyc + 1});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single item into an empty pipe with out_ready=1: literal latency and values.
    task automatic directed(input logic [15:0] v, input logic [1:0] m,
                            input int ef, input int em, input int efit);
        in_valid = 1'b1;
        in_value = v;
        in_mode  = m;
        step();
        in_valid = 1'b0;
        chk("lat1_out_valid", int'(out_valid), 0);
        step();
        chk("lat2_out_valid", int'(out_valid), 1);
        chk("dir_field", int'(out_field), ef);
        chk("dir_mode", int'(out_mode), em);
        chk("dir_fit", int'(out_fit), efit);
        step();
    endtask

    task automatic drain();
        int w;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (q.size() > 0 && w < 50) begin
            step();
            w++;
        end
        chk("drain_left", q.size(), 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int k;
        int d0;
        int r;
        int sv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_field", int'(out_field), 0);
        chk("rst_out_mode", int'(out_mode), 0);
        chk("rst_out_fit", int'(out_fit), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Basic encodes with literal expectations.
`ifdef AUTO_MODE_EN
        directed(16'h000F, 2'd3, 'h00F, 0, 1);
        directed(16'hFFF8, 2'd3, 'h018, 1, 1);
        directed(16'hFF80, 2'd0, 'h080, 2, 1);
        chk("err_before_unfit", int'(err_count), 0);
        directed(16'h0400, 2'd0, 'h400, 3, 0);
        chk("err_after_unfit", int'(err_count), 1);
`else
        directed(16'h0013, 2'd0, 'h013, 0, 1);
        directed(16'hFFF0, 2'd1, 'h010, 1, 1);
        chk("err_before_unfit", int'(err_count), 0);
        directed(16'h0080, 2'd2, 'h080, 2, 0);
        chk("err_after_unfit", int'(err_count), 1);
`endif

        // Back-to-back stream of 8 with a 3-cycle consumer stall.
        sent = 0;
        k    = 0;
        d0   = delivered;
        while (sent < 8 && k < 100) begin
            in_valid  = 1'b1;
            in_value  = 16'(sent * 37 - 100);
            in_mode   = 2'(sent);
            out_ready = !(k >= 3 && k < 6);
            @(negedge clk);
            if (in_ready) sent++;
            step();
            k++;
        end
        drain();
        chk("stall_delivered", delivered - d0, 8);

        // Saturation of err_count with 260 unfit items.
        sent = 0;
        k    = 0;
        while (sent < 260 && k < 1000) begin
            in_valid  = 1'b1;
            in_value  = 16'h7FFF;
            in_mode   = 2'd0;
            out_ready = 1'b1;
            @(negedge clk);
            if (in_ready) sent++;
            step();
            k++;
        end
        drain();
        chk("err_saturated", int'(err_count), 'hFF);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 16'h0005;
        in_mode   = 2'd0;
        repeat (3) step();
        in_valid = 1'b0;
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_err_count", int'(err_count), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        step();

        // Randomized traffic with mixed value ranges and backpressure.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 4);
            case (r)
                0: sv = $urandom_range(0, 31);
                1: sv = $urandom_range(0, 31) - 16;
                2: sv = $urandom_range(0, 255) - 128;
                3: sv = $urandom_range(0, 2047) - 1024;
                default: sv = $urandom_range(0, 65535);
            endcase
            in_value = 16'(sv);
            in_mode  = 2'($urandom_range(0, 3));
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
